oc8051_ports_gen: RTL and testbench
===================================

Name: oc8051_ports_gen

Overview:
- Parametrised successor to the fixed four-port 8051 I/O block.
- NPORTS 8-bit ports, each with:
  - output latch
  - per-pin direction register
  - multi-stage input synchroniser
  - read-modify-write data mux
- Optional per-pin falling-edge interrupt flags.
- Sits between the SFR write path (decoder/ALU) and the chip pads; p_data feeds the SFR read mux.

Parameters:
- NPORTS, 4, number of 8-bit ports (1..8).
- SFR_BASE, 8'h80, byte address of port 0 latch. Must be a multiple of 8.
- SFR_STRIDE, 8'h10, address step between port latches. Must be a multiple of 8.
- DIR_BASE, 8'hF8, byte address of port 0 direction register. Port n is at DIR_BASE+n.
- IFLG_BASE, 8'hF0, byte address of port 0 interrupt flag register. Port n is at IFLG_BASE+n. Used only with the optional feature.
- RST_VAL, 8'hFF, reset value of every output latch.
- SYNC, 2, input synchroniser depth (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- wr  in  1  SFR write strobe
- wr_bit  in  1  bit-addressed write when 1
- wr_addr  in  8  write address
- data_in  in  8  byte write data
- bit_in  in  1  bit write data
- rmw  in  1  read-modify-write select
- p_in  in  8*NPORTS  pad inputs; port n occupies [8n+7:8n]
- p_out  out  8*NPORTS  output latches
- p_oe  out  8*NPORTS  pad output enable (1 = drive)
- p_data  out  8*NPORTS  read data to the SFR mux
- irq  out  1  OR of all flags; present only with OC8051_PORT_IRQ_EN

Behaviour:
- Reset (rst low, asynchronous):
  - p_out = RST_VAL per port
  - p_oe = 0 (all pins input)
  - synchroniser stages = 8'hFF
  - flags = 0; irq = 0
- Release of rst is sampled on clk; the first write is accepted on the first rising edge with rst high.
- Address decode:
  - Port n latch address: LA(n) = SFR_BASE + n*SFR_STRIDE.
  - Byte writes (wr=1, wr_bit=0):
    - wr_addr == LA(n): p_out[n] <= data_in.
    - wr_addr == DIR_BASE+n: p_oe[n] <= data_in.
    - wr_addr == IFLG_BASE+n: flags[n] <= flags[n] & data_in (write 0 clears, write 1 has no effect).
  - Bit writes (wr=1, wr_bit=1):
    - wr_addr[7:3] == LA(n)[7:3]: p_out[n][wr_addr[2:0]] <= bit_in.
    - Direction and flag registers are not bit-addressable; bit writes to them are ignored.
  - Unmatched addresses: no state change.
  - Writes take effect on the next rising edge; p_out and p_oe update one cycle after the write cycle.
  - When several register addresses coincide (misconfigured parameters), port-latch decode takes priority. Parameters must be chosen so that no addresses overlap.
- Synchroniser:
  - p_in passes through SYNC flops per bit; sync_in is the last stage.
  - Latency from pad change to sync_in is SYNC clk edges.
- Read data, per bit:
  - p_data = rmw ? p_out : (p_oe ? p_out : sync_in).
  - Pins driven as outputs read back the latch even when rmw=0.
  - Combinational from the registers.
- Simultaneous byte and bit write in one cycle is impossible (single strobe). wr_bit selects the decode.

Optional Feature:
- Macro: OC8051_PORT_IRQ_EN.
- Defined:
  - Per-pin flag register, plus one extra flop per pin holding the previous sync_in.
  - A flag bit sets when the pin is an input (p_oe=0) and its previous sync_in is 1 while the current sync_in is 0 (falling edge).
  - The flag sets one cycle after sync_in falls.
  - Set has priority over a same-cycle clear of the same bit.
  - irq = registered OR of all flags; it rises one cycle after the flag sets.
  - Edges on output pins are ignored.
- Not defined:
  - No flag or edge flops, no irq port.
  - Writes to IFLG_BASE+n are ignored.

Test Plan:
- Reset then release, NPORTS=4:
  - p_out == 32'hFFFFFFFF, p_oe == 0, p_data == 32'hFFFFFFFF with p_in all ones.
- Byte write 8'h5A to 8'hA0:
  - p_out[23:16] == 8'h5A next cycle.
  - Other ports unchanged.
- Bit write bit_in=0 to 8'h93:
  - p_out[11] == 0.
  - Remaining bits of port 1 unchanged.
- Write DIR 8'hF0 to 8'hF8, set p_in[7:0]=8'h00, rmw=0, with p_out[7:0] at reset value 8'hFF:
  - After SYNC cycles, p_data[7:0] == 8'hF0 (upper nibble from latch, lower nibble from pins).
  - With rmw=1, p_data[7:0] == 8'hFF.
- Change p_in[0] 1->0:
  - sync_in follows exactly SYNC cycles later.
  - With OC8051_PORT_IRQ_EN: flag bit 0 set one cycle after that; irq=1 on the following cycle.
  - Byte write 8'hFE to 8'hF0 clears the flag; irq=0 one cycle after the flag clears.
- Assert rst low mid-write:
  - All registers reset immediately without waiting for clk.
  - The write is lost.

Source files
------------

// File: rtl/oc8051_ports_gen.sv
// Parametrised 8051 I/O ports: output latches, direction registers, input synchronisers
// and read-modify-write read mux. Define OC8051_PORT_IRQ_EN for per-pin falling-edge flags and irq.
module oc8051_ports_gen #(
  parameter int         NPORTS     = 4,
  parameter logic [7:0] SFR_BASE   = 8'h80,
  parameter logic [7:0] SFR_STRIDE = 8'h10,
  parameter logic [7:0] DIR_BASE   = 8'hF8,
  parameter logic [7:0] IFLG_BASE  = 8'hF0,
  parameter logic [7:0] RST_VAL    = 8'hFF,
  parameter int         SYNC       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  wr_bit,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            data_in,
  input  logic                  bit_in,
  input  logic                  rmw,
  input  logic [8*NPORTS-1:0]   p_in,
  output logic [8*NPORTS-1:0]   p_out,
  output logic [8*NPORTS-1:0]   p_oe,
  output logic [8*NPORTS-1:0]   p_data
`ifdef OC8051_PORT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int W = 8 * NPORTS;

  if (NPORTS < 1 || NPORTS > 8 || SYNC < 1 || SYNC > 3 ||
      SFR_BASE[2:0] != 3'd0 || SFR_STRIDE[2:0] != 3'd0 ||
      ((int'(IFLG_BASE) < int'(DIR_BASE) + NPORTS) &&
       (int'(DIR_BASE) < int'(IFLG_BASE) + NPORTS))) begin : g_param_check
    $error("oc8051_ports_gen: illegal parameter combination");
  end

  function automatic logic [7:0] latch_addr(input int n);
    return SFR_BASE + 8'(n) * SFR_STRIDE;
  endfunction

  logic [NPORTS-1:0][7:0] out_q, out_d;
  logic [NPORTS-1:0][7:0] oe_q, oe_d;
  logic [W-1:0]           sync_q [SYNC];
  logic [W-1:0]           sync_in;
  logic                   latch_hit;
`ifdef OC8051_PORT_IRQ_EN
  logic                   dir_hit;
  logic [W-1:0]           flag_mask;
  logic [W-1:0]           prev_q, flag_q;
  logic                   irq_q;
`endif

  assign sync_in = sync_q[SYNC-1];

  // Byte writes go to the port latch first, then direction, then flags, so overlapping
  // addresses from a bad parameter set resolve deterministically.
  always_comb begin
    logic [7:0] la;
    logic [7:0] tmp;
    out_d     = out_q;
    oe_d      = oe_q;
    latch_hit = 1'b0;
`ifdef OC8051_PORT_IRQ_EN
    dir_hit   = 1'b0;
    flag_mask = '1;
`endif
    for (int n = 0; n < NPORTS; n++) begin
      la  = latch_addr(n);
      tmp = out_q[n];
      if (wr && wr_bit && wr_addr[7:3] == la[7:3]) begin
        tmp[wr_addr[2:0]] = bit_in;
        out_d[n]          = tmp;
      end
      if (wr && !wr_bit && wr_addr == la) begin
        out_d[n]  = data_in;
        latch_hit = 1'b1;
      end
    end
    for (int n = 0; n < NPORTS; n++) begin
      if (wr && !wr_bit && !latch_hit && wr_addr == DIR_BASE + 8'(n)) begin
        oe_d[n] = data_in;
`ifdef OC8051_PORT_IRQ_EN
        dir_hit = 1'b1;
`endif
      end
    end
`ifdef OC8051_PORT_IRQ_EN
    for (int n = 0; n < NPORTS; n++) begin
      if (wr && !wr_bit && !latch_hit && !dir_hit && wr_addr == IFLG_BASE + 8'(n))
        flag_mask[8*n +: 8] = data_in;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= {NPORTS{RST_VAL}};
      oe_q  <= '0;
      for (int i = 0; i < SYNC; i++) sync_q[i] <= '1;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      sync_q[0] <= p_in;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef OC8051_PORT_IRQ_EN
  // prev_q resets to all ones to match the synchroniser, so release never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '1;
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= sync_in;
      flag_q <= (flag_q & flag_mask) | (prev_q & ~sync_in & ~oe_q);
      irq_q  <= |flag_q;
    end
  end

  assign irq = irq_q;
`endif

  assign p_out  = out_q;
  assign p_oe   = oe_q;
  assign p_data = rmw ? out_q : ((oe_q & out_q) | (~oe_q & sync_in));

endmodule

// File: tb/tb_oc8051_ports_gen.sv
// Self-checking bench for oc8051_ports_gen: directed test-plan steps followed by random
// SFR traffic, all compared against a behavioural model of the port registers.
module tb_oc8051_ports_gen;

  localparam int         NPORTS     = 4;
  localparam int         W          = 8 * NPORTS;
  localparam int         SYNC       = 2;
  localparam logic [7:0] SFR_BASE   = 8'h80;
  localparam logic [7:0] SFR_STRIDE = 8'h10;
  localparam logic [7:0] DIR_BASE   = 8'hF8;
  localparam logic [7:0] IFLG_BASE  = 8'hF0;
  localparam logic [7:0] RST_VAL    = 8'hFF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr = 1'b0, wr_bit = 1'b0, bit_in = 1'b0, rmw = 1'b0;
  logic [7:0]   wr_addr = 8'h00, data_in = 8'h00;
  logic [W-1:0] p_in = '1;
  logic [W-1:0] p_out, p_oe, p_data;
`ifdef OC8051_PORT_IRQ_EN
  logic         irq;
`endif

  oc8051_ports_gen #(
    .NPORTS(NPORTS), .SFR_BASE(SFR_BASE), .SFR_STRIDE(SFR_STRIDE), .DIR_BASE(DIR_BASE),
    .IFLG_BASE(IFLG_BASE), .RST_VAL(RST_VAL), .SYNC(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .data_in(data_in),
    .bit_in(bit_in), .rmw(rmw), .p_in(p_in), .p_out(p_out), .p_oe(p_oe), .p_data(p_data)
`ifdef OC8051_PORT_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents per port plus a history of pad values.
  logic [7:0]   m_out  [NPORTS];
  logic [7:0]   m_oe   [NPORTS];
  logic [7:0]   m_flag [NPORTS];
  logic         m_irq;
  logic [W-1:0] m_prev_sync;
  logic [W-1:0] in_hist [$];

  function automatic logic [7:0] la(input int n);
    return 8'(int'(SFR_BASE) + n * int'(SFR_STRIDE));
  endfunction

  // The synchronised value is simply the pad value seen SYNC edges ago.
  function automatic logic [W-1:0] modelSync();
    if (in_hist.size() < SYNC) return '1;
    return in_hist[in_hist.size() - SYNC];
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int n = 0; n < NPORTS; n++) begin
      m_out[n]  = RST_VAL;
      m_oe[n]   = 8'h00;
      m_flag[n] = 8'h00;
    end
    m_irq       = 1'b0;
    m_prev_sync = '1;
    in_hist.delete();
  endtask

  task automatic modelEdge();
    logic [W-1:0] cur;
    logic [7:0]   setb [NPORTS];
    logic [7:0]   clr  [NPORTS];
    logic         hit;
    logic         any_flag;
    cur = modelSync();
    any_flag = 1'b0;
    for (int n = 0; n < NPORTS; n++) begin
      setb[n] = m_prev_sync[8*n +: 8] & ~cur[8*n +: 8] & ~m_oe[n];
      clr[n]  = 8'hFF;
      if (m_flag[n] != 8'h00) any_flag = 1'b1;
    end
    if (wr) begin
      hit = 1'b0;
      if (wr_bit) begin
        for (int n = 0; n < NPORTS; n++)
          if ((wr_addr & 8'hF8) == la(n)) m_out[n][wr_addr[2:0]] = bit_in;
      end else begin
        for (int n = 0; n < NPORTS; n++)
          if (wr_addr == la(n)) begin m_out[n] = data_in; hit = 1'b1; end
        if (!hit)
          for (int n = 0; n < NPORTS; n++)
            if (int'(wr_addr) == int'(DIR_BASE) + n) begin m_oe[n] = data_in; hit = 1'b1; end
        if (!hit)
          for (int n = 0; n < NPORTS; n++)
            if (int'(wr_addr) == int'(IFLG_BASE) + n) clr[n] = data_in;
      end
    end
    for (int n = 0; n < NPORTS; n++) m_flag[n] = (m_flag[n] & clr[n]) | setb[n];
    m_irq       = any_flag;
    m_prev_sync = cur;
    in_hist.push_back(p_in);
    if (in_hist.size() > SYNC) void'(in_hist.pop_front());
  endtask

  task automatic checkAll();
    logic [W-1:0] e_out, e_oe, e_data, s;
    s = modelSync();
    for (int n = 0; n < NPORTS; n++) begin
      e_out[8*n +: 8] = m_out[n];
      e_oe[8*n +: 8]  = m_oe[n];
    end
    for (int b = 0; b < W; b++)
      e_data[b] = rmw ? e_out[b] : (e_oe[b] ? e_out[b] : s[b]);
    checkOutput("p_out", p_out, e_out);
    checkOutput("p_oe", p_oe, e_oe);
    checkOutput("p_data", p_data, e_data);
`ifdef OC8051_PORT_IRQ_EN
    checkOutput("irq", W'(irq), W'(m_irq));
`endif
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare just after the edge.
  task automatic applyStimulus(input logic i_wr, input logic i_bit, input logic [7:0] i_addr,
                               input logic [7:0] i_data, input logic i_bin, input logic i_rmw,
                               input logic [W-1:0] i_pin);
    wr = i_wr; wr_bit = i_bit; wr_addr = i_addr; data_in = i_data;
    bit_in = i_bin; rmw = i_rmw; p_in = i_pin;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idle(input int cycles, input logic i_rmw, input logic [W-1:0] i_pin);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, i_rmw, i_pin);
  endtask

  initial begin
    logic [W-1:0] pins;
    logic [7:0]   addr;
    int           sel;

    // Reset and release
    rst = 1'b0;
    modelReset();
    #22;
    checkAll();
    checkOutput("rst_p_out", p_out, 32'hFFFFFFFF);
    checkOutput("rst_p_oe", p_oe, 32'h0);
    checkOutput("rst_p_data", p_data, 32'hFFFFFFFF);
    @(negedge clk);
    rst = 1'b1;

    // Byte write to port 2 latch
    applyStimulus(1'b1, 1'b0, 8'hA0, 8'h5A, 1'b0, 1'b0, '1);
    checkOutput("bytewr_p2", W'(p_out[23:16]), W'(8'h5A));
    checkOutput("bytewr_others", p_out | 32'h00FF0000, 32'hFFFFFFFF);

    // Bit write clears p1.3
    applyStimulus(1'b1, 1'b1, 8'h93, 8'h00, 1'b0, 1'b0, '1);
    checkOutput("bitwr_p1", W'(p_out[15:8]), W'(8'hF7));

    // Direction split with pins low
    applyStimulus(1'b1, 1'b0, 8'hF8, 8'hF0, 1'b0, 1'b0, '1);
    idle(SYNC, 1'b0, {24'hFFFFFF, 8'h00});
    checkOutput("dir_rd_mix", W'(p_data[7:0]), W'(8'hF0));
    idle(1, 1'b1, {24'hFFFFFF, 8'h00});
    checkOutput("dir_rd_rmw", W'(p_data[7:0]), W'(8'hFF));

    // Pins back high, clear any pending flags, then a single falling edge on p0.0
    idle(SYNC + 1, 1'b0, '1);
    applyStimulus(1'b1, 1'b0, IFLG_BASE, 8'h00, 1'b0, 1'b0, '1);
    idle(2, 1'b0, '1);
`ifdef OC8051_PORT_IRQ_EN
    checkOutput("irq_idle", W'(irq), '0);
`endif
    idle(SYNC - 1, 1'b0, 32'hFFFFFFFE);
    checkOutput("sync_not_yet", W'(p_data[0]), W'(1'b1));
    idle(1, 1'b0, 32'hFFFFFFFE);
    checkOutput("sync_follow", W'(p_data[0]), W'(1'b0));
    idle(1, 1'b0, 32'hFFFFFFFE);
`ifdef OC8051_PORT_IRQ_EN
    checkOutput("irq_before", W'(irq), '0);
`endif
    idle(1, 1'b0, 32'hFFFFFFFE);
`ifdef OC8051_PORT_IRQ_EN
    checkOutput("irq_rise", W'(irq), W'(1'b1));
`endif
    applyStimulus(1'b1, 1'b0, IFLG_BASE, 8'hFE, 1'b0, 1'b0, 32'hFFFFFFFE);
    idle(1, 1'b0, 32'hFFFFFFFE);
`ifdef OC8051_PORT_IRQ_EN
    checkOutput("irq_clear", W'(irq), '0);
`endif

    // Asynchronous reset in the middle of a write
    wr = 1'b1; wr_bit = 1'b0; wr_addr = 8'hA0; data_in = 8'h00;
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkAll();
    checkOutput("async_rst_p2", W'(p_out[23:16]), W'(8'hFF));
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    wr = 1'b0;
    rst = 1'b1;
    idle(1, 1'b0, '1);
    checkOutput("write_lost", W'(p_out[23:16]), W'(8'hFF));

    // Random SFR traffic
    pins = '1;
    for (int i = 0; i < 500; i++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       addr = la(int'($urandom_range(0, NPORTS - 1)));
        1:       addr = la(int'($urandom_range(0, NPORTS - 1))) | 8'($urandom_range(0, 7));
        2:       addr = DIR_BASE + 8'($urandom_range(0, NPORTS - 1));
        3:       addr = IFLG_BASE + 8'($urandom_range(0, NPORTS - 1));
        default: addr = 8'($urandom);
      endcase
      pins = pins ^ ($urandom & $urandom & $urandom);
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), addr, 8'($urandom),
                    1'($urandom), 1'($urandom_range(0, 3) == 0), pins);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
